imem_loader: RTL and testbench

- Boot-time program loader between the host byte stream and the `cpu` instruction-memory write port.
- Accepts a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the `cpu` in reset until the last word is committed, then releases it; the CPU always starts fetching from a fully loaded image.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot loader that turns a length-prefixed byte stream into
// instruction-memory word writes and holds the cpu in reset until done.
// Ports:
//   clk, rst         clock, async active-high reset
//   in_valid/ready   byte handshake, in_data is the stream byte
//   mem_we/addr/wdata  one-cycle instruction-memory write port
//   cpu_rst          cpu reset, released after the last word commits
//   loading, error   status; words_loaded counts committed words
module imem_loader #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH_WORDS   = 256,
  parameter logic [ADDRESS_WIDTH-1:0] LOAD_BASE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst,
  output logic                     loading,
  output logic                     error,
  output logic [15:0]              words_loaded
);

  typedef enum logic [1:0] {
    S_LEN,
    S_LOAD,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  byte_cnt;
  logic [23:0] low;
  logic [31:0] len;
  logic [31:0] word_cnt;
  logic        accept;
  logic        last_byte;
  logic [31:0] full;

  assign in_ready  = (state == S_LEN) || (state == S_LOAD);
  assign loading   = in_ready;
  assign error     = (state == S_ERR);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign full      = {in_data, low};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LEN: begin
        if (last_byte) begin
          if (full == 32'd0)
            state_nx = S_RUN;
          else if (full > DEPTH_WORDS)
            state_nx = S_ERR;
          else
            state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_byte && (word_cnt + 32'd1 == len))
          state_nx = S_RUN;
      end
      S_RUN:   state_nx = S_RUN;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_LEN;
    endcase
  end

  // cpu_rst is registered off the state so it falls one edge after RUN
  // is entered, i.e. on the same edge the memory commits the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt     <= 2'd0;
      low          <= 24'd0;
      len          <= 32'd0;
      word_cnt     <= 32'd0;
      words_loaded <= 16'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
    end else begin
      mem_we  <= 1'b0;
      cpu_rst <= (state != S_RUN);
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        unique case (byte_cnt)
          2'd0: low[7:0]   <= in_data;
          2'd1: low[15:8]  <= in_data;
          2'd2: low[23:16] <= in_data;
          default: begin
            if (state == S_LEN) begin
              len <= full;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= LOAD_BASE
                         + ADDRESS_WIDTH'({word_cnt, 2'b00});
              mem_wdata <= DATA_WIDTH'(full);
              word_cnt  <= word_cnt + 32'd1;
              if (words_loaded != 16'hFFFF)
                words_loaded <= words_loaded + 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized streams against a queue-based image model.
// Checks write addresses, data, strobe latency and cpu release timing.
module tb_imem_loader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] BASE_B = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic in_ready, mem_we, cpu_rst, loading, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [15:0] words_loaded;

  logic b_in_ready, b_mem_we, b_cpu_rst, b_loading, b_error;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata;
  logic [15:0] b_words_loaded;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel_cyc = -1;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [31:0] ba[$];
  logic [7:0]  stream[$];
  logic [31:0] img[$];
  int          acc[$];

  imem_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .loading(loading),
    .error(error), .words_loaded(words_loaded)
  );

  imem_loader #(.LOAD_BASE(BASE_B)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_rst(b_cpu_rst), .loading(b_loading),
    .error(b_error), .words_loaded(b_words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (b_mem_we) ba.push_back(b_mem_addr);
    if (!rst && !cpu_rst && rel_cyc < 0) rel_cyc = cyc;
  end

  function automatic void build(input logic [31:0] n);
    logic [31:0] w;
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
    for (int k = 0; k < img.size(); k++) begin
      w = img[k];
      for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    end
  endfunction

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    wc.delete();
    ba.delete();
    rel_cyc = -1;
  endtask

  // Reset with a live byte on the bus: reset must win and drop it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    clear_mon();
    #1;
  endtask

  // mode 0: every cycle, 1: valid toggles, 2: random stalls
  task automatic send(input int mode);
    int idx;
    int waited;
    bit v;
    bit tog;
    idx = 0;
    waited = 0;
    tog = 1'b1;
    acc.delete();
    while (idx < stream.size()) begin
      @(negedge clk);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin v = tog; tog = !tog; end
      else v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      in_data = v ? stream[idx] : 8'($urandom);
      if (v && in_ready) begin
        acc.push_back(cyc);
        idx++;
        waited = 0;
      end else if (v) begin
        waited++;
        if (waited > 100) begin
          tests++;
          fails++;
          $display("FAIL send_timeout in_ready got 0 want 1 byte %0d", idx);
          break;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_image(input int n, input int mode,
                            input bit keep, input string nm);
    int lim;
    int exp;
    do_reset();
    if (!keep) begin
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
    end
    build(n);
    send(mode);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (wa.size() !== n) begin
      fails++;
      $display("FAIL %s_count got %0d want %0d", nm, wa.size(), n);
    end
    lim = (wa.size() < n) ? wa.size() : n;
    for (int i = 0; i < lim; i++) begin
      tests++;
      if (wa[i] !== 32'(4 * i)) begin
        fails++;
        $display("FAIL %s_addr[%0d] got %h want %h", nm, i, wa[i], 4 * i);
      end
      tests++;
      if (wd[i] !== img[i]) begin
        fails++;
        $display("FAIL %s_data[%0d] got %h want %h", nm, i, wd[i], img[i]);
      end
      if (acc.size() == stream.size()) begin
        exp = acc[4 * i + 7] + 1;
        tests++;
        if (wc[i] !== exp) begin
          fails++;
          $display("FAIL %s_lat[%0d] got %0d want %0d", nm, i, wc[i], exp);
        end
      end
    end
    tests++;
    if (ba.size() !== n) begin
      fails++;
      $display("FAIL %s_bcount got %0d want %0d", nm, ba.size(), n);
    end
    lim = (ba.size() < n) ? ba.size() : n;
    for (int i = 0; i < lim; i++) begin
      tests++;
      if (ba[i] !== BASE_B + 32'(4 * i)) begin
        fails++;
        $display("FAIL %s_baddr[%0d] got %h want %h", nm, i, ba[i],
                 BASE_B + 32'(4 * i));
      end
    end
    if (acc.size() == stream.size()) begin
      exp = acc[acc.size() - 1] + 2;
      tests++;
      if (rel_cyc !== exp) begin
        fails++;
        $display("FAIL %s_release got %0d want %0d", nm, rel_cyc, exp);
      end
    end
    tests++;
    if (words_loaded !== 16'(n)) begin
      fails++;
      $display("FAIL %s_words got %0d want %0d", nm, words_loaded, n);
    end
    tests++;
    if ({in_ready, loading, error, cpu_rst, b_cpu_rst} !== 5'b0) begin
      fails++;
      $display("FAIL %s_status got rdy=%b ld=%b err=%b cr=%b bcr=%b want 0",
               nm, in_ready, loading, error, cpu_rst, b_cpu_rst);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    tests++;
    if ({cpu_rst, mem_we, error} !== 3'b100) begin
      fails++;
      $display("FAIL reset_ctl got cr=%b we=%b err=%b want 1 0 0",
               cpu_rst, mem_we, error);
    end
    tests++;
    if (mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== 16'd0) begin
      fails++;
      $display("FAIL reset_regs got a=%h d=%h w=%0d want 0",
               mem_addr, mem_wdata, words_loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({in_ready, loading, cpu_rst} !== 3'b111) begin
      fails++;
      $display("FAIL reset_release got rdy=%b ld=%b cr=%b want 1 1 1",
               in_ready, loading, cpu_rst);
    end
  endtask

  task automatic test_single_word();
    img.delete();
    img.push_back(32'h00A00513);
    test_image(1, 0, 1'b1, "single");
  endtask

  task automatic test_toggle_valid();
    test_image(3, 1, 1'b0, "toggle");
  endtask

  task automatic test_back_to_back();
    test_image(int'($urandom_range(2, 8)), 0, 1'b0, "b2b");
  endtask

  task automatic test_random_stall();
    for (int r = 0; r < 3; r++)
      test_image(int'($urandom_range(1, 12)), 2, 1'b0, "stall");
  endtask

  task automatic test_full_depth();
    test_image(256, 0, 1'b0, "full");
  endtask

  task automatic test_zero_len();
    int bad;
    img.delete();
    test_image(0, 0, 1'b1, "zero");
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if (in_ready !== 1'b0) bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bad !== 0 || wa.size() !== 0 || words_loaded !== 16'd0) begin
      fails++;
      $display("FAIL zero_ignore got rdy_cycles=%0d writes=%0d words=%0d want 0",
               bad, wa.size(), words_loaded);
    end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    img.delete();
    build(32'd257);
    send(0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if ({error, cpu_rst, in_ready, mem_we} !== 4'b1100) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL ovf_hold got %0d bad cycles want 0", bad);
    end
    tests++;
    if (wa.size() !== 0 || words_loaded !== 16'd0 || b_error !== 1'b1) begin
      fails++;
      $display("FAIL ovf_nowrite got writes=%0d words=%0d berr=%b want 0 0 1",
               wa.size(), words_loaded, b_error);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    build(32'd2);
    while (stream.size() > 10) void'(stream.pop_back());
    send(0);
    @(negedge clk);
    tests++;
    if (wa.size() !== 1 || rel_cyc !== -1) begin
      fails++;
      $display("FAIL mid_pre got writes=%0d rel=%0d want 1 -1",
               wa.size(), rel_cyc);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    #1;
    tests++;
    if (cpu_rst !== 1'b1 || words_loaded !== 16'd0) begin
      fails++;
      $display("FAIL mid_async got cr=%b words=%0d want 1 0",
               cpu_rst, words_loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    clear_mon();
    img.delete();
    img.push_back(32'hDEADBEEF);
    build(32'd1);
    send(0);
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() !== 1) begin
      fails++;
      $display("FAIL mid_count got %0d want 1", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL mid_word got %h@%h want deadbeef@0", wd[0], wa[0]);
      end
    end
    tests++;
    if (cpu_rst !== 1'b0 || words_loaded !== 16'd1) begin
      fails++;
      $display("FAIL mid_release got cr=%b words=%0d want 0 1",
               cpu_rst, words_loaded);
    end
  endtask

  task automatic test_reset_strobe();
    do_reset();
    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    build(32'd2);
    while (stream.size() > 8) void'(stream.pop_back());
    send(0);
    tests++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL strobe_pre mem_we got %b want 1", mem_we);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (mem_we !== 1'b0 || cpu_rst !== 1'b1) begin
      fails++;
      $display("FAIL strobe_async got we=%b cr=%b want 0 1", mem_we, cpu_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (words_loaded !== 16'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL strobe_after got words=%0d rdy=%b want 0 1",
               words_loaded, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_toggle_valid();
    test_back_to_back();
    test_random_stall();
    test_zero_len();
    test_overflow();
    test_full_depth();
    test_reset_mid();
    test_reset_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
